// File: rtl/min4_stream_reducer.sv
// min4_stream_reducer
//
// Streaming unsigned-minimum reducer. Operands arrive one per valid/ready
// transfer; every GROUP operands the block presents the group minimum on a
// registered output stream. Ties keep the earliest position in the group.
//
// Optional feature macro: MIN4_STREAM_INDEX_EN
//   defined   -> out_idx port exists and reports the 0-based position of the
//                minimum within its group (acc_idx tracking is built).
//   undefined -> out_idx and all index tracking are omitted; out_min,
//                handshakes and timing are unchanged.
//
// Phases are implied by the registers rather than a separate state variable:
//   ACCUM : cnt_q = 0..GROUP-1 (position of the next operand)
//   HOLD  : out_valid_q = 1 (result waiting for the consumer)
// HOLD and ACCUM position 0 overlap only in a cycle where out_ready is high,
// which lets a new group start in the same cycle the previous result retires.

module min4_stream_reducer #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef MIN4_STREAM_INDEX_EN
  output logic [$clog2(GROUP)-1:0] out_idx,
`endif
  output logic [WIDTH-1:0]         out_min
);

  localparam int CNT_W = $clog2(GROUP);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(GROUP - 1);

  // A group of one has no accumulation phase and would let a completing
  // input collide with a pending result; reject it at elaboration.
  if (GROUP < 2) begin : g_group_check
    $error("min4_stream_reducer: GROUP must be at least 2");
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] acc_min_q,   acc_min_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_min_q,   out_min_d;
`ifdef MIN4_STREAM_INDEX_EN
  logic [CNT_W-1:0] acc_idx_q,   acc_idx_d;
  logic [CNT_W-1:0] out_idx_q,   out_idx_d;
`endif

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  logic in_xfer;
  logic out_xfer;
  logic first_pos;
  logic last_pos;
  logic is_lower;

  // Ready whenever no result is pending, or the pending one retires now.
  assign in_ready  = !reset && (!out_valid_q || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign first_pos = (cnt_q == '0);
  assign last_pos  = (cnt_q == LAST_POS);
  // Strict compare: an equal operand never displaces the earlier minimum.
  assign is_lower  = (in_data < acc_min_q);

  // Next-state logic for the accumulator, position counter and result.
  always_comb begin
    // NOTE: every variable assigned below gets a hold value first, so no
    // path through the branches leaves one unassigned and no latch appears.
    cnt_d       = cnt_q;
    acc_min_d   = acc_min_q;
    out_valid_d = out_valid_q;
    out_min_d   = out_min_q;
`ifdef MIN4_STREAM_INDEX_EN
    acc_idx_d   = acc_idx_q;
    out_idx_d   = out_idx_q;
`endif

    // Retiring a result clears valid; a completing input below can only
    // happen when no result is pending, so the two never fight.
    if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    if (in_xfer) begin
      if (first_pos) begin
        // First operand of a group seeds the running minimum.
        acc_min_d = in_data;
`ifdef MIN4_STREAM_INDEX_EN
        acc_idx_d = '0;
`endif
        cnt_d     = CNT_W'(1);
      end else if (last_pos) begin
        // Final operand: fold it in directly and publish the result.
        out_min_d   = is_lower ? in_data : acc_min_q;
`ifdef MIN4_STREAM_INDEX_EN
        out_idx_d   = is_lower ? cnt_q : acc_idx_q;
`endif
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end else begin
        if (is_lower) begin
          acc_min_d = in_data;
`ifdef MIN4_STREAM_INDEX_EN
          acc_idx_d = cnt_q;
`endif
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values and block ordering cannot change behaviour.
    if (reset) begin
      // NOTE: the datapath registers are reset too, not just the control,
      // because out_min/out_idx are architecturally visible as zero after
      // reset and a discarded partial group must leave no trace.
      cnt_q       <= '0;
      acc_min_q   <= '0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
`ifdef MIN4_STREAM_INDEX_EN
      acc_idx_q   <= '0;
      out_idx_q   <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      acc_min_q   <= acc_min_d;
      out_valid_q <= out_valid_d;
      out_min_q   <= out_min_d;
`ifdef MIN4_STREAM_INDEX_EN
      acc_idx_q   <= acc_idx_d;
      out_idx_q   <= out_idx_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: driven straight from registers, no path from in_data.
  // ---------------------------------------------------------------------
  assign out_valid = out_valid_q;
  assign out_min   = out_min_q;
`ifdef MIN4_STREAM_INDEX_EN
  assign out_idx   = out_idx_q;
`endif

  // ---------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------

  // The position counter never leaves 0..GROUP-1.
  a_cnt_range : assert property (@(posedge clk) disable iff (reset)
    int'(cnt_q) < GROUP);

  // A stalled result stays valid and unchanged.
  a_hold_stable : assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_min_q)));

  // A result only appears right after the final operand of a group.
  a_valid_cause : assert property (@(posedge clk) disable iff (reset)
    $rose(out_valid_q) |-> $past(in_valid && in_ready && (cnt_q == LAST_POS)));

endmodule

// File: tb/tb_min4_stream_reducer.sv
// tb_min4_stream_reducer
//
// Self-checking bench for min4_stream_reducer (WIDTH=8, GROUP=4).
// A queue-based reference model in the monitor predicts in_ready, out_valid,
// out_min (and out_idx when MIN4_STREAM_INDEX_EN is defined) every cycle.
// Directed scenarios additionally pin results to hand-computed literals.

module tb_min4_stream_reducer;

  localparam int WIDTH = 8;
  localparam int GROUP = 4;
  localparam int IDX_W = $clog2(GROUP);

  typedef struct {
    logic [WIDTH-1:0] min;
    logic [IDX_W-1:0] idx;
  } result_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
`ifdef MIN4_STREAM_INDEX_EN
  logic [IDX_W-1:0] out_idx;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rand_mode = 1'b0;

  result_t obs[$];    // results seen leaving the DUT (written by monitor only)
  int      rd_ptr = 0;

  min4_stream_reducer #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MIN4_STREAM_INDEX_EN
    .out_idx   (out_idx),
`endif
    .out_min   (out_min)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model + compare process, sampled on the falling edge.
  // ---------------------------------------------------------------------
  initial begin : monitor
    logic [WIDTH-1:0] grp[$];
    logic             m_ov;
    logic [WIDTH-1:0] m_min;
    logic [IDX_W-1:0] m_idx;
    logic             exp_rdy;
    result_t          r;
    m_ov  = 1'b0;
    m_min = '0;
    m_idx = '0;
    forever begin
      @(negedge clk);
      exp_rdy = !reset && (!m_ov || out_ready);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("out_min", 32'(out_min), 32'(m_min));
`ifdef MIN4_STREAM_INDEX_EN
        check("out_idx", 32'(out_idx), 32'(m_idx));
`endif
      end
      if (!reset && out_valid && out_ready) begin
        r.min = out_min;
`ifdef MIN4_STREAM_INDEX_EN
        r.idx = out_idx;
`else
        r.idx = '0;
`endif
        obs.push_back(r);
      end
      // Advance the model to what the next rising edge must produce.
      if (reset) begin
        grp.delete();
        m_ov  = 1'b0;
        m_min = '0;
        m_idx = '0;
      end else begin
        if (m_ov && out_ready) m_ov = 1'b0;
        if (in_valid && exp_rdy) begin
          grp.push_back(in_data);
          if (grp.size() == GROUP) begin
            m_min = grp[0];
            for (int i = 1; i < GROUP; i++)
              if (grp[i] < m_min) m_min = grp[i];
            m_idx = '0;
            for (int i = GROUP - 1; i >= 0; i--)
              if (grp[i] == m_min) m_idx = IDX_W'(i);
            m_ov = 1'b1;
            grp.delete();
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver helpers (all stimulus changes at posedge + 1).
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: operand 0x%0h not accepted within 500 cycles", d);
    in_valid = 1'b0;
  endtask

  task automatic expect_next(input string name, input logic [WIDTH-1:0] m,
                             input logic [IDX_W-1:0] idx);
    for (int n = 0; n < 50 && obs.size() <= rd_ptr; n++) tick();
    if (obs.size() <= rd_ptr) begin
      checks++;
      errors++;
      $display("FAIL %s: no result within 50 cycles, expected min 0x%0h", name, m);
      return;
    end
    check({name, "_min"}, 32'(obs[rd_ptr].min), 32'(m));
`ifdef MIN4_STREAM_INDEX_EN
    check({name, "_idx"}, 32'(obs[rd_ptr].idx), 32'(idx));
`endif
    rd_ptr++;
  endtask

  task automatic send_group(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin : stim
    int t0;
    int base;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    #1;
    // Reset values.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_min",   32'(out_min),   32'd0);
`ifdef MIN4_STREAM_INDEX_EN
    check("rst_out_idx",   32'(out_idx),   32'd0);
`endif
    check("rst_in_ready",  32'(in_ready),  32'd1);
    tick();

    // Basic group.
    out_ready = 1'b1;
    send_group(8'h01, 8'h02, 8'h03, 8'h04);
    expect_next("basic", 8'h01, 2'd0);

    // Late minimum, back-to-back groups: 8 inputs in 8 cycles.
    t0 = cyc;
    send_group(8'h11, 8'h12, 8'h13, 8'h04);
    send_group(8'h11, 8'h12, 8'h13, 8'h14);
    check("b2b_cycles", 32'(cyc - t0), 32'd8);
    expect_next("late_min", 8'h04, 2'd3);
    expect_next("b2b_second", 8'h11, 2'd0);

    // Ties and extremes.
    send_group(8'h05, 8'h05, 8'h05, 8'h05);
    expect_next("all_equal", 8'h05, 2'd0);
    send_group(8'hFF, 8'h80, 8'h00, 8'h00);
    expect_next("tie_zero", 8'h00, 2'd2);

    // Backpressure: result held for 5 cycles with an operand waiting.
    out_ready = 1'b0;
    send_group(8'h20, 8'h10, 8'h30, 8'h40);
    in_valid = 1'b1;
    in_data  = 8'h07;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_min",   32'(out_min),   32'h10);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    send(8'h07);
    expect_next("bp_result", 8'h10, 2'd1);
    send(8'h08);
    send(8'h09);
    send(8'h0A);
    expect_next("bp_next_group", 8'h07, 2'd0);

    // Reset mid-group discards the partial group.
    send(8'h01);
    send(8'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send_group(8'h09, 8'h08, 8'h07, 8'h06);
    expect_next("after_rst", 8'h06, 2'd3);
    repeat (3) tick();
    check("no_partial_result", 32'(obs.size() - rd_ptr), 32'd0);

    // Reset during HOLD clears out_valid on the next cycle.
    out_ready = 1'b0;
    send_group(8'h33, 8'h22, 8'h11, 8'h44);
    check("hold_before_rst", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("hold_rst_valid", 32'(out_valid), 32'd0);
    check("hold_rst_min",   32'(out_min),   32'd0);
    tick();
    out_ready = 1'b1;
    tick();

    // Randomised groups with input gaps and random consumer stalls.
    base      = obs.size();
    rand_mode = 1'b1;
    for (int g = 0; g < 100; g++) begin
      for (int k = 0; k < GROUP; k++) begin
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        if ($urandom_range(0, 3) == 0)
          send(WIDTH'($urandom_range(0, 3)));
        else
          send(WIDTH'($urandom_range(0, 255)));
      end
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    check("random_groups", 32'(obs.size() - base), 32'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
